pcileech_tlps128_tx_arbiter: RTL
================================

# pcileech_tlps128_tx_arbiter

Packet-atomic round-robin arbiter that merges several 128-bit TLP source streams into the single TLP stream sent to the PCIe core transmit interface. It sits directly downstream of the shadow config-space completion generator (the cfg-response stream is source 0) and of the BAR/other completion generators. It also provides a one-entry registered output stage and per-source packet counters for debug readout.

## Interface
Parameters:
- NUM_SRC, 4, number of source streams (2..8).
- USER_W, 9, tuser width carried through unmodified.

Ports:
- clk_pcie  in  1  PCIe user clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- src_tdata  in  NUM_SRC×128  per-source TLP beat data.
- src_tkeepdw  in  NUM_SRC×4  per-source valid-DW mask.
- src_tlast  in  NUM_SRC  last beat of a TLP.
- src_tuser  in  NUM_SRC×USER_W  sideband, passed through.
- src_tvalid  in  NUM_SRC  beat valid.
- src_tready  out  NUM_SRC  beat accepted when tvalid&&tready.
- out_tdata  out  128  merged stream data.
- out_tkeepdw  out  4  merged DW mask.
- out_tlast  out  1  merged last.
- out_tuser  out  USER_W  merged sideband.
- out_tvalid  out  1  output beat valid.
- out_tready  in  1  PCIe core ready.
- pkt_cnt  out  NUM_SRC×16  per-source count of completed TLPs (tlast accepted), wraps.

## Operation
- States: IDLE (no source owns the output), LOCKED (lock_idx owns it until its tlast beat is accepted).
- can_load = !out_tvalid || out_tready (output register empty or draining this cycle).
- IDLE: winner = first i with src_tvalid[i] scanning rr_ptr, rr_ptr+1, … mod NUM_SRC. If any valid and can_load: src_tready[winner]=1, beat loaded. If that beat has tlast: stay IDLE, rr_ptr <= winner+1 mod NUM_SRC. Else: go LOCKED, lock_idx <= winner.
- LOCKED: src_tready[lock_idx] = can_load; all others 0. Beat accepted with tlast -> IDLE, rr_ptr <= lock_idx+1 mod NUM_SRC. Source deasserting tvalid mid-packet holds the lock (no timeout).
- At most one src_tready high per cycle; src_tready never depends on src_tvalid of a non-granted source in LOCKED.
- Output register: loaded on any accepted beat; out_tvalid cleared when out_tready && no new load.
- pkt_cnt[i] increments by 1 (mod 2^16) on each accepted src beat with tlast from source i.

## Timing
- Reset (synchronous, rst high at posedge): state=IDLE, rr_ptr=0, out_tvalid=0, out_tdata=0, out_tkeepdw=0, out_tlast=0, out_tuser=0, all pkt_cnt=0. src_tready is 0 while rst high.
- Latency: accepted source beat appears on out_* the next cycle.
- Throughput: one beat/cycle sustained when out_tready stays high; back-to-back single-beat TLPs from different sources with no idle cycle.
- out_* stable while out_tvalid && !out_tready.
- Reset mid-packet: lock dropped, pending output beat discarded; no recovery of partial TLP (upstream sources also reset).
- rr_ptr wrap: NUM_SRC-1 -> 0.
- Simultaneous out_tready and new load: beat replaced in the same edge, no bubble.

## Structure
- Shared package pcileech_tlp_pkg: state enum (S_ARB_IDLE, S_ARB_LOCKED), TLP beat struct {tdata, tkeepdw, tlast, tuser}.
- One sub-module: pcileech_rr_pick (combinational rotate-priority picker: req vector + start pointer -> one-hot grant + index).

## Test plan
- Single source 0 sends 3-DW cfg completion (tkeepdw=4'b0111, tlast=1), out_tready=1 -> out_tvalid one cycle later with identical data, pkt_cnt[0]=1.
- All 4 sources hold single-beat TLPs continuously, out_tready=1 -> output order 0,1,2,3,0,… with no gaps.
- Source 1 sends 3-beat TLP while source 2 valid; source 1 drops tvalid for 5 cycles after beat 1 -> no source-2 beat until source-1 tlast accepted, then source 2.
- out_tready toggled 1/0 randomly during 2-source traffic -> out_* unchanged while stalled, no beats lost or duplicated (scoreboard).
- rst asserted while locked mid-packet -> next cycle out_tvalid=0, all src_tready=0, pkt_cnt=0; after release source 0 wins first.
- 65536 single-beat TLPs on source 3 -> pkt_cnt[3] wraps to 0.

Source files
------------

// File: rtl/pcileech_tlp_pkg.sv
// Shared TLP stream types for the 128-bit transmit path: arbiter state encoding
// and the beat record carried through the output register.
package pcileech_tlp_pkg;

  localparam int TLP_DATA_W = 128;
  localparam int TLP_KEEP_W = 4;
  localparam int TLP_USER_W = 9;
  localparam int PKT_CNT_W  = 16;

  typedef enum logic [0:0] {
    S_ARB_IDLE   = 1'b0,
    S_ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [TLP_DATA_W-1:0] tdata;
    logic [TLP_KEEP_W-1:0] tkeepdw;
    logic                  tlast;
    logic [TLP_USER_W-1:0] tuser;
  } tlp_beat_t;

endpackage

// File: rtl/pcileech_tlps128_tx_arbiter_if.sv
// Bundle of the per-source TLP streams and the merged stream toward the PCIe core.
// master = upstream generators plus core; slave = the arbiter.
interface pcileech_tlps128_tx_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int USER_W  = 9
) ();

  logic [NUM_SRC-1:0][127:0]      src_tdata;
  logic [NUM_SRC-1:0][3:0]        src_tkeepdw;
  logic [NUM_SRC-1:0]             src_tlast;
  logic [NUM_SRC-1:0][USER_W-1:0] src_tuser;
  logic [NUM_SRC-1:0]             src_tvalid;
  logic [NUM_SRC-1:0]             src_tready;

  logic [127:0]      out_tdata;
  logic [3:0]        out_tkeepdw;
  logic              out_tlast;
  logic [USER_W-1:0] out_tuser;
  logic              out_tvalid;
  logic              out_tready;

  modport master (
    output src_tdata, src_tkeepdw, src_tlast, src_tuser, src_tvalid,
    input  src_tready,
    input  out_tdata, out_tkeepdw, out_tlast, out_tuser, out_tvalid,
    output out_tready
  );

  modport slave (
    input  src_tdata, src_tkeepdw, src_tlast, src_tuser, src_tvalid,
    output src_tready,
    output out_tdata, out_tkeepdw, out_tlast, out_tuser, out_tvalid,
    input  out_tready
  );

endinterface

// File: rtl/pcileech_rr_pick.sv
// Rotating-priority picker: first asserted request scanning from start upward,
// wrapping modulo N. Purely combinational.
module pcileech_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan the rotated request order; the first hit freezes idx.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (!any && req[(int'(start) + k) % N]) ? IDX_W'((int'(start) + k) % N) : idx;
      any = any | req[(int'(start) + k) % N];
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/pcileech_tlps128_tx_arbiter.sv
// Packet-atomic round-robin merge of NUM_SRC TLP streams into one registered
// output stream, with per-source completed-TLP counters.
module pcileech_tlps128_tx_arbiter
  import pcileech_tlp_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int USER_W  = TLP_USER_W
) (
  input  logic                               clk_pcie,
  input  logic                               rst,
  pcileech_tlps128_tx_arbiter_if.slave       bus,
  output logic [NUM_SRC-1:0][PKT_CNT_W-1:0]  pkt_cnt
);

  localparam int IDX_W = $clog2(NUM_SRC);

  generate
    if (NUM_SRC < 2 || NUM_SRC > 8 || USER_W != TLP_USER_W) begin : g_param_check
      $error("pcileech_tlps128_tx_arbiter: unsupported NUM_SRC/USER_W");
    end
  endgenerate

  arb_state_e                         state_r;
  logic [IDX_W-1:0]                   rr_ptr_r;
  logic [IDX_W-1:0]                   lock_idx_r;
  tlp_beat_t                          out_beat_r;
  logic                               out_tvalid_r;
  logic [NUM_SRC-1:0][PKT_CNT_W-1:0]  pkt_cnt_r;

  logic [NUM_SRC-1:0]  pick_gnt_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic [NUM_SRC-1:0]  src_tready_s;
  logic                can_load_s;
  logic                accept_s;
  tlp_beat_t           sel_beat_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    next_idx = (i == IDX_W'(NUM_SRC - 1)) ? {IDX_W{1'b0}} : i + IDX_W'(1);
  endfunction

  pcileech_rr_pick #(.N(NUM_SRC), .IDX_W(IDX_W)) u_pick (
    .req   (bus.src_tvalid),
    .start (rr_ptr_r),
    .gnt   (pick_gnt_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  assign can_load_s = !out_tvalid_r || bus.out_tready;

  // Grant the picker's winner while idle, only the lock owner while locked.
  always_comb begin
    src_tready_s = '0;
    sel_idx_s    = lock_idx_r;
    case (state_r)
      S_ARB_IDLE: begin
        sel_idx_s = pick_idx_s;
        if (!rst && pick_any_s && can_load_s) begin
          src_tready_s = pick_gnt_s;
        end else begin
          src_tready_s = '0;
        end
      end
      S_ARB_LOCKED: begin
        sel_idx_s = lock_idx_r;
        if (!rst && can_load_s) begin
          src_tready_s[lock_idx_r] = 1'b1;
        end else begin
          src_tready_s = '0;
        end
      end
      default: begin
        src_tready_s = '0;
        sel_idx_s    = lock_idx_r;
      end
    endcase
  end

  assign accept_s   = |(src_tready_s & bus.src_tvalid);
  assign sel_beat_s = '{tdata:   bus.src_tdata[sel_idx_s],
                        tkeepdw: bus.src_tkeepdw[sel_idx_s],
                        tlast:   bus.src_tlast[sel_idx_s],
                        tuser:   bus.src_tuser[sel_idx_s]};

  // Lock/round-robin state, output register and completed-TLP counters.
  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      state_r      <= S_ARB_IDLE;
      rr_ptr_r     <= '0;
      lock_idx_r   <= '0;
      out_beat_r   <= '0;
      out_tvalid_r <= 1'b0;
      pkt_cnt_r    <= '0;
    end else begin
      if (accept_s) begin
        out_beat_r   <= sel_beat_s;
        out_tvalid_r <= 1'b1;
      end else if (bus.out_tready) begin
        out_tvalid_r <= 1'b0;
      end

      if (accept_s && sel_beat_s.tlast) begin
        pkt_cnt_r[sel_idx_s] <= pkt_cnt_r[sel_idx_s] + PKT_CNT_W'(1);
      end

      case (state_r)
        S_ARB_IDLE: begin
          if (accept_s) begin
            if (sel_beat_s.tlast) begin
              rr_ptr_r <= next_idx(sel_idx_s);
            end else begin
              state_r    <= S_ARB_LOCKED;
              lock_idx_r <= sel_idx_s;
            end
          end
        end
        // A stalled owner keeps the lock indefinitely; only its tlast frees it.
        S_ARB_LOCKED: begin
          if (accept_s && sel_beat_s.tlast) begin
            state_r  <= S_ARB_IDLE;
            rr_ptr_r <= next_idx(lock_idx_r);
          end
        end
        default: state_r <= S_ARB_IDLE;
      endcase
    end
  end

  assign bus.src_tready  = src_tready_s;
  assign bus.out_tdata   = out_beat_r.tdata;
  assign bus.out_tkeepdw = out_beat_r.tkeepdw;
  assign bus.out_tlast   = out_beat_r.tlast;
  assign bus.out_tuser   = out_beat_r.tuser;
  assign bus.out_tvalid  = out_tvalid_r;
  assign pkt_cnt         = pkt_cnt_r;

endmodule
